// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I pipeline stage registers.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_t;

  localparam int PIPE_CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_data_reg.sv
// Load-enabled payload register with synchronous reset to a configurable value.
module pipe_data_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= RESET_VALUE;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready on both sides, 2-entry skid buffer, flush.
// Define PIPE_STAGE_STATS_EN to add the saturating stall_cnt output.
module pipe_stage_reg
  import rv_pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = PIPE_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  pipe_state_t      state, state_nxt;
  logic             in_fire, out_fire;
  logic             main_ld, skid_ld;
  logic [WIDTH-1:0] main_d, skid_q;

  // Both handshake outputs decode the state register only, so out_ready
  // never reaches in_ready combinationally.
  assign out_valid = (state != ST_EMPTY);
  assign in_ready  = (state != ST_TWO);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    main_ld   = 1'b0;
    skid_ld   = 1'b0;
    main_d    = in_data;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_ld   = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_ld = 1'b1;
          end else if (in_fire) begin
            skid_ld   = 1'b1;
            state_nxt = ST_TWO;
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            main_ld   = 1'b1;
            main_d    = skid_q;
            state_nxt = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_nxt;
  end

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
    .clk (clk),
    .rst (rst),
    .ld  (main_ld),
    .d   (main_d),
    .q   (out_data)
  );

  pipe_data_reg #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (skid_ld),
    .d   (in_data),
    .q   (skid_q)
  );

`ifdef PIPE_STAGE_STATS_EN
  // Counts stalled cycles across flushes; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, streaming, stats, random vs queue model.
module tb_pipe_stage_reg;

  localparam int          W   = 32;
  localparam logic [31:0] RV  = 32'hDEAD_BEEF;
`ifdef PIPE_STAGE_STATS_EN
  localparam int          CW  = 4;
`else
  localparam int          CW  = 16;
`endif
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [CW-1:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mq[$];
  int          stall_m = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .RESET_VALUE(RV), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock with model update; the model is a FIFO queue of held beats.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy);
    logic m_ir, m_ov;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    m_ir = (mq.size() < 2);
    m_ov = (mq.size() > 0);
    if (r) begin
      mq.delete();
      stall_m = 0;
    end else begin
      if (m_ov && !ordy && stall_m < CMAX) stall_m++;
      if (m_ov && ordy) begin
        chk("deliver", out_data, mq[0]);
        void'(mq.pop_front());
      end
      if (f) mq.delete();
      else if (iv && m_ir) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    if (mq.size() > 0) chk("out_data", out_data, mq[0]);
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", {{(32-CW){1'b0}}, stall_cnt}, stall_m);
`endif
  endtask

  typedef struct {
    logic        rst, flush, iv, ordy;
    logic [31:0] d;
    logic        ev, er, chk_d;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic r, logic f, logic iv, logic [31:0] d, logic ordy,
                              logic ev, logic er, logic cd, logic [31:0] ed);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ev = ev; v.er = er; v.chk_d = cd; v.ed = ed;
    return v;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //           rst  fl  iv  data   ordy  ev  er  cd  exp_data
    vecs[0]  = mk(1, 0, 0, 32'h0,  0,  0, 1, 1, RV);
    vecs[1]  = mk(1, 0, 0, 32'h0,  0,  0, 1, 1, RV);
    vecs[2]  = mk(0, 0, 1, 32'hA1, 0,  1, 1, 1, 32'hA1);
    vecs[3]  = mk(0, 0, 1, 32'hA2, 0,  1, 0, 1, 32'hA1);
    vecs[4]  = mk(0, 0, 1, 32'hA3, 0,  1, 0, 1, 32'hA1);
    vecs[5]  = mk(0, 0, 0, 32'h0,  1,  1, 1, 1, 32'hA2);
    vecs[6]  = mk(0, 0, 0, 32'h0,  1,  0, 1, 1, 32'hA2);
    vecs[7]  = mk(0, 0, 1, 32'h11, 0,  1, 1, 1, 32'h11);
    vecs[8]  = mk(0, 0, 1, 32'h22, 0,  1, 0, 1, 32'h11);
    vecs[9]  = mk(0, 1, 1, 32'h33, 0,  0, 1, 1, 32'h11);
    vecs[10] = mk(0, 0, 0, 32'h0,  1,  0, 1, 1, 32'h11);
    vecs[11] = mk(0, 0, 1, 32'h44, 0,  1, 1, 1, 32'h44);
    vecs[12] = mk(0, 1, 1, 32'h55, 0,  0, 1, 1, 32'h44);
    vecs[13] = mk(0, 0, 0, 32'h0,  0,  0, 1, 1, 32'h44);
    vecs[14] = mk(0, 0, 1, 32'h66, 0,  1, 1, 1, 32'h66);
    vecs[15] = mk(0, 0, 1, 32'h77, 0,  1, 0, 1, 32'h66);
    vecs[16] = mk(1, 0, 0, 32'h0,  0,  0, 1, 1, RV);

    for (int i = 0; i < 17; i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush; in_valid = vecs[i].iv;
      in_data = vecs[i].d; out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].er});
      if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
`ifdef PIPE_STAGE_STATS_EN
      if (vecs[i].rst) chk($sformatf("vec%0d_stall", i), {{(32-CW){1'b0}}, stall_cnt}, 32'd0);
`endif
    end

    // Model is empty after the final reset vector; continue with the model-driven steps.
    mq.delete(); stall_m = 0;
    step(1, 0, 0, 32'h0, 0);

    // Streaming: one beat per cycle, 1-cycle latency, in_ready never drops.
    for (int i = 1; i <= 100; i++) begin
      step(0, 0, 1, i, 1);
      chk("stream_data", out_data, i);
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    step(0, 0, 0, 32'h0, 1);
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_STAGE_STATS_EN
    step(1, 0, 0, 32'h0, 0);
    step(0, 0, 1, 32'hC0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, 0);
    chk("stall_sat", {{(32-CW){1'b0}}, stall_cnt}, 32'd15);
    step(0, 1, 0, 32'h0, 0);
    chk("stall_after_flush", {{(32-CW){1'b0}}, stall_cnt}, 32'd15);
    step(1, 0, 0, 32'h0, 0);
    chk("stall_after_rst", {{(32-CW){1'b0}}, stall_cnt}, 32'd0);
`endif

    // Random traffic with occasional flushes.
    step(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 10000; i++) begin
      step(0, ($urandom_range(0, 99) < 2), $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    end
    // Drain without new input; every held beat must come out in order.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1);
    chk("random_drained", mq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
